// File: rtl/bcd_disp_pkg.sv
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Segment glyph constants and bit-order definitions shared by
//               the BCD scan display driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_disp_pkg;

    localparam int SEG_W     = 7;
    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    // Glyphs are packed {g,f,e,d,c,b,a}, active-high
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational BCD to 7-segment decoder; codes 10-15 show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bcd_scan_display.sv
// ============================================================================
// Module      : bcd_scan_display
// Description : Time-multiplexed 7-segment driver with frame-coherent digit
//               updates and a dark guard cycle per digit slot.
//               Optional macro LZ_BLANK_EN enables leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    load,
    output logic [SEG_W-1:0]        seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int c_p_w   = $clog2(SCAN_DIV);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_p_w-1:0]   c_p_last   = c_p_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    logic [c_p_w-1:0]        r_p;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pend;
    logic [SEG_W-1:0]        r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_start;

    logic                    w_boundary;
    logic                    w_dark;
    logic [3:0]              w_digit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [SEG_W-1:0]        w_seg_dec;
    logic                    w_blank;

    assign w_dark     = (r_p == '0);
    assign w_boundary = w_dark && (r_idx == '0);

    always_comb begin
        w_digit  = 4'd0;
        w_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_digit     = r_active[4*k +: 4];
                w_onehot[k] = 1'b1;
            end
        end
    end

    bcd_to_seg u_dec (
        .bcd (w_digit),
        .seg (w_seg_dec)
    );

`ifdef LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_dig_zero;
    logic [NUM_DIGITS-1:0] w_lead_zero;

    genvar gk;
    generate
        for (gk = 0; gk < NUM_DIGITS; gk++) begin : g_dig_zero
            assign w_dig_zero[gk] = (r_active[4*gk +: 4] == 4'd0);
        end
    endgenerate

    // w_lead_zero[k]: every digit from k up to the most significant is zero
    always_comb begin
        logic v_run;
        v_run       = 1'b1;
        w_lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_run          = v_run & w_dig_zero[k];
            w_lead_zero[k] = v_run;
        end
    end

    assign w_blank = (r_idx != '0) && w_lead_zero[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_p           <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_active      <= '0;
            r_pend        <= 1'b0;
            r_seg         <= '0;
            r_an          <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (r_p == c_p_last) begin
                r_p   <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_p <= r_p + 1'b1;
            end

            if (load) begin
                r_shadow <= digits;
            end

            // A load on the boundary edge bypasses the shadow register
            if (w_boundary) begin
                if (load) begin
                    r_active <= digits;
                end else if (r_pend) begin
                    r_active <= r_shadow;
                end
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend <= 1'b1;
            end

            r_an          <= w_dark ? '0 : w_onehot;
            r_seg         <= (w_dark || w_blank) ? SEG_BLANK : w_seg_dec;
            r_frame_start <= w_boundary;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: doc/bcd_scan_display.md
# bcd_scan_display

- Multiplexed 7-segment display driver: the consumer end of the BCD counter chain.
- Accepts NUM_DIGITS packed BCD digits from upstream counters (e.g. the 0–9 decade counter `q`) and decodes them to segments.
- Time-multiplexes one digit at a time onto shared segment lines, with one dark guard cycle per digit against ghosting.
- Updates are frame-coherent, so a count change never tears mid-scan.

## Interface
- NUM_DIGITS, 4, number of scanned digits (1..8)
- SCAN_DIV, 1000, clock cycles per digit slot including guard cycle (min 2)
- clk  in  1  system clock, rising edge
- clr  in  1  reset; one clock domain, synchronous and active-high
- digits  in  4*NUM_DIGITS  packed BCD, digit 0 (least significant) in bits [3:0]
- load  in  1  capture strobe for `digits`, sampled every edge
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- an  out  NUM_DIGITS  digit enable, one-hot or all-zero, active-high
- frame_start  out  1  one-cycle pulse at start of each scan frame

## Operation
- State registers:
  - phase counter `p` (0..SCAN_DIV-1)
  - digit index `idx` (0..NUM_DIGITS-1)
  - `shadow` and `active` digit registers
  - `pend` flag
- Each edge with clr=0:
  - if p==SCAN_DIV-1: p←0 and idx advances, wrapping NUM_DIGITS-1→0
  - otherwise p←p+1
- Load path:
  - load=1 copies `digits` into `shadow` and sets pend.
  - Repeated loads before transfer: last one wins.
- Frame transfer happens at an edge where p==0 and idx==0 (pre-edge values):
  - if pend: active←shadow, pend←0.
  - If load=1 on that same edge: active←`digits` directly (bypass), pend stays 0.
- Segment decode of active digit `idx`:
  - 0–9: standard glyphs.
  - 10–15: dash (g only, 7'b1000000).
  - Blank: 7'b0000000.
- Reset value of every register and output is 0: p, idx, shadow, active, pend, seg, an, frame_start.
- clr mid-frame: all state returns to 0 on that edge and scanning restarts from digit 0. Pending load is discarded.

## Timing
- Outputs are registered, one cycle after counter state. With p(t), idx(t) the pre-edge values:
  - an(t+1) = 0 if p(t)==0, else onehot(idx(t))
  - seg(t+1) = 0 if p(t)==0, else decode(active digit idx(t))
  - frame_start(t+1) = 1 iff p(t)==0 and idx(t)==0
- Per digit slot: 1 dark cycle, then SCAN_DIV-1 lit cycles. Frame length is NUM_DIGITS*SCAN_DIV cycles.
- After clr deasserts:
  - first edge: frame_start=1, an=0
  - digit 0 lit from the second edge onward
- seg and an always change on the same edge; there is never a lit cycle with a stale glyph.
- A load is visible at the first frame boundary at or after the load edge. Worst-case latency ≈ one frame + 1 cycle.

## Configuration
- LZ_BLANK_EN defined: leading-zero blanking.
  - Digit k is blanked (seg=0, an still asserted) when active digits k..NUM_DIGITS-1 are all 0 and k>0.
  - Digit 0 is always displayed.
  - Invalid codes (10–15) count as non-zero.
- LZ_BLANK_EN undefined: all digits are displayed, zeros shown as "0".

## Structure
- Package `bcd_disp_pkg`:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - segment bit-order localparams
- Sub-module `bcd_to_seg`: purely combinational 4-bit→7-bit decoder, instantiated once on the muxed active digit.
- Top level holds the counters, shadow/active registers, blanking logic and output registers.

## Test plan
All with NUM_DIGITS=4, SCAN_DIV=4, so a frame is 16 cycles.
- Reset then idle:
  - clr=1 for 2 cycles, then 0.
  - an sequence per frame: 0,1,1,1, 0,2,2,2, 0,4,4,4, 0,8,8,8 (hex one-hot).
  - seg=7'b0111111 ("0") on lit cycles, LZ_BLANK_EN off.
  - frame_start every 16 cycles.
- Load 16'h1234 mid-frame (digit 2 lit):
  - current frame still shows 0s.
  - next frame digit0=SEG_4 (7'b1100110), digit1=SEG_3, digit2=SEG_2, digit3=SEG_1.
- Invalid code: load 16'h00A7 → digit1 shows 7'b1000000.
  - with LZ_BLANK_EN, digits 2–3 have seg=0 while an is asserted.
- Simultaneous load and frame boundary: load 16'h9999 on the edge where p==0, idx==0 → digit 0 of that same frame shows SEG_9.
- Back-to-back loads 16'h1111 then 16'h2222 within one frame → only 16'h2222 is ever displayed.
- clr pulse at digit 2 → next edge all outputs 0; active=0 and the pending load is dropped. Scan restarts with frame_start one edge after clr deasserts.
